// File: rtl/fetch_control_pkg.sv
// Shared types and constants for the pipeline fetch/flush controller and its hazard compare.
package fetch_control_pkg;

  localparam int REG_W  = 5;
  localparam int ZR_IDX = 31;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_RUN    = 2'd0;
  localparam fsm_state_t ST_DRAIN  = 2'd1;
  localparam fsm_state_t ST_HALTED = 2'd2;

  // Control word carried through ID/EX and EX/MEM; a bubble or flush loads CTRL_NOP.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/fetch_control_load_use_detect.sv
// Load-use hazard compare: a load in EX feeding a source of the instruction in ID.
// Purely combinational, zero latency; the zero register never creates a hazard.
module load_use_detect
  import fetch_control_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  output logic             hazard
);

  logic rd_is_zr;
  logic rn_match;
  logic rm_match;

  always_comb begin
    rd_is_zr = (ex_rd == REG_W'(ZR_IDX));
    rn_match = (ex_rd == id_rn);
    rm_match = id_uses_rm && (ex_rd == id_rm);
    hazard   = ex_mem_read && !rd_is_zr && (rn_match || rm_match);
  end

endmodule

// File: rtl/fetch_control.sv
// Pipeline control: PC/IF-ID/ID-EX/EX-MEM enables and flushes for stall, redirect, load-use and HLT drain.
// Outputs combinational from state+inputs; FETCH_CTRL_PERF_EN adds stall/redirect counters.
module fetch_control
  import fetch_control_pkg::*;
#(
  parameter int DRAIN_CYC = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic             id_hlt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_branch_taken,
  input  logic             dmem_stall,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             halted
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      redirect_count
`endif
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             load_use;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rm  (id_uses_rm),
    .hazard      (load_use)
  );

  always_comb begin
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_write    = 1'b1;
    idex_bubble   = 1'b0;
    exmem_flush   = 1'b0;
    halted        = 1'b0;
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (state_q == ST_HALTED) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      halted     = 1'b1;
    end else if (dmem_stall) begin
      // Whole pipe frozen; MEM will re-present any branch next cycle.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (mem_branch_taken) begin
      pc_sel_branch = 1'b1;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      exmem_flush   = 1'b1;
      state_d       = ST_RUN;
      drain_cnt_d   = '0;
    end else if (state_q == ST_DRAIN) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      drain_cnt_d = drain_cnt_q - CNT_W'(1);
      if (drain_cnt_q == CNT_W'(1)) begin
        state_d = ST_HALTED;
      end
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_hlt) begin
      // HLT itself flows on into ID/EX; its control word is already NOP-equivalent.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      state_d     = ST_DRAIN;
      drain_cnt_d = CNT_W'(DRAIN_CYC);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] redirect_count_q, redirect_count_d;

  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    redirect_count_d = redirect_count_q;
    if (!pc_write && (state_q != ST_HALTED) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (pc_sel_branch && (redirect_count_q != '1)) begin
      redirect_count_d = redirect_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Randomised + directed bench for fetch_control with a queue-decoupled scoreboard.
module tb_fetch_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rm, id_hlt, ex_mem_read, mem_branch_taken, dmem_stall;
  logic       pc_write, pc_sel_branch, ifid_write, ifid_flush;
  logic       idex_write, idex_bubble, exmem_flush, halted;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cycles, redirect_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  // Reference state: halted flag plus number of drain cycles still owed.
  bit m_halt  = 1'b0;
  int m_drain = 0;

  always #5 clock = ~clock;

  fetch_control #(.DRAIN_CYC(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .id_rn            (id_rn),
    .id_rm            (id_rm),
    .id_uses_rm       (id_uses_rm),
    .id_hlt           (id_hlt),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .mem_branch_taken (mem_branch_taken),
    .dmem_stall       (dmem_stall),
    .pc_write         (pc_write),
    .pc_sel_branch    (pc_sel_branch),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_write       (idex_write),
    .idex_bubble      (idex_bubble),
    .exmem_flush      (exmem_flush),
    .halted           (halted)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .stall_cycles     (stall_cycles),
    .redirect_count   (redirect_count)
`endif
  );

  // Vector order: pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_flush, halted
  task automatic step(input bit rst, input bit stall, input bit br, input bit ld,
                      input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                      input bit urm, input bit hlt);
    logic [7:0] e;
    bit hz;
    reset = rst; dmem_stall = stall; mem_branch_taken = br; ex_mem_read = ld;
    ex_rd = rd; id_rn = rn; id_rm = rm; id_uses_rm = urm; id_hlt = hlt;
    hz = ld && (rd != 5'd31) && ((rd == rn) || (urm && (rd == rm)));
    if (rst) begin
      e = 8'b0001_0110; m_halt = 1'b0; m_drain = 0;
    end else if (m_halt) begin
      e = 8'b0000_0001;
    end else if (stall) begin
      e = 8'b0000_0000;
    end else if (br) begin
      e = 8'b1111_1110; m_drain = 0;
    end else if (m_drain > 0) begin
      e = 8'b0001_1000;
      m_drain--;
      if (m_drain == 0) m_halt = 1'b1;
    end else if (hz) begin
      e = 8'b0000_1100;
    end else if (hlt) begin
      e = 8'b0000_1000; m_drain = 3;
    end else begin
      e = 8'b1010_1000;
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
  endtask

  // Monitor: outputs are valid every cycle, so each negedge consumes one expectation.
  initial begin
    logic [7:0] exp_v, got;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got = {pc_write, pc_sel_branch, ifid_write, ifid_flush,
               idex_write, idex_bubble, exmem_flush, halted};
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL ctrl_vec t=%0t got=%b required=%b", $time, got, exp_v);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; dmem_stall = 0; mem_branch_taken = 0; ex_mem_read = 0;
    ex_rd = 0; id_rn = 0; id_rm = 0; id_uses_rm = 0; id_hlt = 0;
    @(posedge clock);
    #1;
    // Reset for two cycles, then quiet running.
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    // Load-use on rn, zero-register dest, and unused rm match.
    step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 5'd31, 5'd31, 5'd31, 1, 0);
    step(0, 0, 0, 1, 5'd5, 5'd7, 5'd5, 0, 0);
    step(0, 0, 0, 1, 5'd5, 5'd7, 5'd5, 1, 0);
    // Branch beats load-use.
    step(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    // Stall masks the branch, which redirects on the following cycle.
    step(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    step(0, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    idle(1);
    // HLT: three drain cycles then halted held until reset.
    step(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1);
    idle(3);
    for (int i = 0; i < 12; i++) step(0, i[0], i[1], 1, 5'd5, 5'd5, 5'd5, 1, 1);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);
    // HLT with a stall pulse mid-drain.
    step(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1);
    idle(1);
    step(0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    // HLT then wrong-path branch on the second drain cycle.
    step(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1);
    idle(1);
    step(0, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    idle(5);
    // Reset in the middle of a stall and of a drain.
    step(0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    step(1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1);
    step(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    idle(2);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] pool [4];
      pool[0] = 5'd5; pool[1] = 5'd7; pool[2] = 5'd31; pool[3] = 5'($urandom);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
           pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
           pool[$urandom_range(0, 3)], $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
